adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder.sv | 196 +++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_responder.sv
// adc_spi_responder: SPI-style ADC responder. A convst rise snapshots the
// hold register and runs a fixed-length conversion. The result is then shifted
// out LSB first on sck rises, while a configuration word is captured from sdi.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned MODE_W      = 6,
  parameter int unsigned CONV_CYCLES = 80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              convst,
  input  logic              sck,
  input  logic              sdi,
  output logic              sdo,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              busy,
  output logic [MODE_W-1:0] mode_out,
  output logic              mode_valid,
  output logic              frame_done,
  output logic              frame_error
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned CCNT_W = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2
  } state_t;

  // Synchronizer chains: stage 1, stage 2, and a third copy for edge detection
  logic r_convst_s1, r_convst_s2, r_convst_s3;
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_sdi_s1, r_sdi_s2;

  // Start-up qualification of convst after reset release
  logic [1:0] r_settle;
  logic       r_armed;

  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic [MODE_W-1:0] r_mode_sr;
  logic [BCNT_W-1:0] r_bit_cnt;
  logic [CCNT_W-1:0] r_conv_cnt;
  state_t            r_state;

  logic              w_convst_rise;
  logic              w_sck_rise;
  logic [DATA_W-1:0] w_hold_next;
  logic [DATA_W-1:0] w_shifted;
  logic              w_shift_bit;
  logic [MODE_W-1:0] w_mode_next;
  logic              w_bit_avail;
  logic              w_last_bit;

  // Double-flop synchronizers plus delayed copies for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_convst_s1 <= 1'b0;
      r_convst_s2 <= 1'b0;
      r_convst_s3 <= 1'b0;
      r_sck_s1    <= 1'b0;
      r_sck_s2    <= 1'b0;
      r_sck_s3    <= 1'b0;
      r_sdi_s1    <= 1'b0;
      r_sdi_s2    <= 1'b0;
    end else begin
      r_convst_s1 <= convst;
      r_convst_s2 <= r_convst_s1;
      r_convst_s3 <= r_convst_s2;
      r_sck_s1    <= sck;
      r_sck_s2    <= r_sck_s1;
      r_sck_s3    <= r_sck_s2;
      r_sdi_s1    <= sdi;
      r_sdi_s2    <= r_sdi_s1;
    end
  end

  // convst edges count only after it has been seen low once the chain has
  // refilled, so a level held high across reset release is not a start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd2) && !r_convst_s2) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign w_convst_rise = r_armed & r_convst_s2 & ~r_convst_s3;
  assign w_sck_rise    = r_sck_s2 & ~r_sck_s3;

  // A sample arriving in the same cycle as a start is the one captured
  assign w_hold_next = sample_valid ? sample_data : r_hold;

  assign w_shifted   = r_shift >> r_bit_cnt;
  assign w_shift_bit = w_shifted[0];
  assign w_bit_avail = (r_bit_cnt < BCNT_W'(DATA_W));
  assign w_last_bit  = (r_bit_cnt == BCNT_W'(DATA_W - 1));

  // Configuration bits enter at the MSB so the first bit lands at bit 0
  assign w_mode_next = (r_bit_cnt < BCNT_W'(MODE_W)) ?
                       {r_sdi_s2, r_mode_sr[MODE_W-1:1]} : r_mode_sr;

  // Hold register follows sample_valid regardless of state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
    end else if (sample_valid) begin
      r_hold <= sample_data;
    end
  end

  // Main control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_mode_sr   <= '0;
      r_bit_cnt   <= '0;
      r_conv_cnt  <= '0;
      sdo         <= 1'b0;
      busy        <= 1'b0;
      mode_out    <= '0;
      mode_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      mode_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          sdo  <= 1'b0;
          busy <= 1'b0;
          if (w_convst_rise) begin
            r_shift    <= w_hold_next;
            r_bit_cnt  <= '0;
            r_conv_cnt <= CCNT_W'(CONV_CYCLES);
            busy       <= 1'b1;
            r_state    <= ST_CONVERT;
          end
        end

        ST_CONVERT: begin
          sdo  <= 1'b0;
          busy <= 1'b1;
          if (r_conv_cnt != '0) begin
            r_conv_cnt <= r_conv_cnt - CCNT_W'(1);
          end else if (!r_convst_s2) begin
            // Conversion time elapsed and convst released
            busy    <= 1'b0;
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          busy <= 1'b0;
          if (w_convst_rise) begin
            // A restart wins over a coincident sck edge; a partial frame is an error
            frame_error <= (r_bit_cnt != '0);
            sdo         <= 1'b0;
            r_shift     <= w_hold_next;
            r_bit_cnt   <= '0;
            r_conv_cnt  <= CCNT_W'(CONV_CYCLES);
            busy        <= 1'b1;
            r_state     <= ST_CONVERT;
          end else if (w_sck_rise && w_bit_avail) begin
            sdo       <= w_shift_bit;
            r_mode_sr <= w_mode_next;
            r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
            if (w_last_bit) begin
              frame_done <= 1'b1;
              mode_out   <= w_mode_next;
              mode_valid <= 1'b1;
              r_state    <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed and randomized bench for adc_spi_responder with a bit-level frame model.
module tb_adc_spi_responder;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned MODE_W      = 6;
  localparam int unsigned CONV_CYCLES = 80;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              convst = 1'b0;
  logic              sck = 1'b0;
  logic              sdi = 1'b0;
  logic              sdo;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              busy;
  logic [MODE_W-1:0] mode_out;
  logic              mode_valid;
  logic              frame_done;
  logic              frame_error;

  adc_spi_responder #(
    .DATA_W(DATA_W),
    .MODE_W(MODE_W),
    .CONV_CYCLES(CONV_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .convst(convst),
    .sck(sck),
    .sdi(sdi),
    .sdo(sdo),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .busy(busy),
    .mode_out(mode_out),
    .mode_valid(mode_valid),
    .frame_done(frame_done),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_fd = 0;
  int n_mv = 0;
  int n_fe = 0;
  int cyc = 0;
  int t_busy = 0;
  logic [MODE_W-1:0] m_mode = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters: each one-cycle pulse is seen at exactly one falling edge
  always @(negedge clk) begin
    if (frame_done)  n_fd++;
    if (mode_valid)  n_mv++;
    if (frame_error) n_fe++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({sdo, busy, mode_out, mode_valid, frame_done, frame_error});
  endfunction

  task automatic load_sample(input logic [DATA_W-1:0] v);
    @(negedge clk);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    sample_data  = DATA_W'($urandom);
  endtask

  // Raise convst; busy must appear on the third clock after the rise
  task automatic conv_start();
    @(negedge clk);
    convst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("busy_before", 32'(busy), 32'd0);
    @(posedge clk);
    #1 check("busy_rise", 32'(busy), 32'd1);
    t_busy = cyc;
  endtask

  // Hold convst, drop it, then wait for busy to clear
  task automatic conv_end(input int hold_cycles);
    int c0;
    repeat (hold_cycles) @(posedge clk);
    #1 check("busy_while_convst", 32'(busy), 32'd1);
    @(negedge clk);
    convst = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
    end
    check("busy_fall", 32'(busy), 32'd0);
    check("busy_min_len", 32'((cyc - t_busy) >= int'(CONV_CYCLES)), 32'd1);
    check("busy_after_convst_low", 32'(cyc >= c0 + 3), 32'd1);
    check("sdo_before_first_sck", 32'(sdo), 32'd0);
  endtask

  // One sck cycle (9 clk); sdo and frame_done sampled one clk after the synced edge
  task automatic sck_edge(input logic b, output logic so, output logic fd);
    @(negedge clk);
    sdi = b;
    @(negedge clk);
    sck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    so = sdo;
    fd = frame_done;
    repeat (2) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Clock n_edges sck edges in SHIFT and compare against the frame model
  task automatic run_frame(input logic [DATA_W-1:0] val, input logic [31:0] bits,
                           input int n_edges, input string tag);
    int fd0, mv0, fe0;
    logic so, fd;
    logic complete;
    logic [MODE_W-1:0] exp_mode;
    fd0 = n_fd;
    mv0 = n_mv;
    fe0 = n_fe;
    exp_mode = '0;
    complete = (n_edges >= int'(DATA_W));
    for (int i = 0; i < n_edges; i++) begin
      sck_edge(bits[i], so, fd);
      check($sformatf("%s_sdo%0d", tag, i), 32'(so), 32'((val >> i) & 1));
      check($sformatf("%s_fd%0d", tag, i), 32'(fd), 32'(i == int'(DATA_W) - 1));
      if (i < int'(MODE_W)) exp_mode = exp_mode | (MODE_W'(bits[i]) << i);
    end
    if (complete) m_mode = exp_mode;
    repeat (2) @(negedge clk);
    check({tag, "_sdo_after"}, 32'(sdo),
          complete ? 32'd0 : 32'((val >> (n_edges - 1)) & 1));
    check({tag, "_fd_count"}, 32'(n_fd - fd0), 32'(complete));
    check({tag, "_mv_count"}, 32'(n_mv - mv0), 32'(complete));
    check({tag, "_fe_count"}, 32'(n_fe - fe0), 32'd0);
    check({tag, "_mode_out"}, 32'(mode_out), 32'(m_mode));
  endtask

  initial begin
    logic [DATA_W-1:0] v, v2;
    logic [31:0] bits;
    logic so, fd;
    int fe0, fd0, mv0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 check("reset_outs", outs_vec(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("post_reset_outs", outs_vec(), 32'd0);

    // Known sample 0xA5C with a 1 us convst pulse and config 1,0,1,1,0,0
    load_sample(12'hA5C);
    conv_start();
    conv_end(97);
    bits = ($urandom & ~32'h3F) | 32'h0D;
    run_frame(12'hA5C, bits, 12, "a5c");
    check("a5c_mode_literal", 32'(mode_out), 32'h0D);

    // Randomized frames; first one also restarts with n = 0 (no error)
    for (int k = 0; k < 3; k++) begin
      v = DATA_W'($urandom);
      load_sample(v);
      conv_start();
      conv_end($urandom_range(2, 20));
      if (k == 0) begin
        fe0 = n_fe;
        conv_start();
        repeat (2) @(negedge clk);
        check("restart_n0_no_error", 32'(n_fe - fe0), 32'd0);
        conv_end(5);
      end
      run_frame(v, $urandom, 12, $sformatf("rnd%0d", k));
    end

    // Abort after 5 edges; the restart captures the newer sample
    v  = DATA_W'($urandom);
    v2 = ~v;
    load_sample(v);
    conv_start();
    conv_end(10);
    run_frame(v, $urandom, 5, "abort_pre");
    load_sample(v2);
    fe0 = n_fe;
    mv0 = n_mv;
    conv_start();
    repeat (2) @(negedge clk);
    check("abort_fe_count", 32'(n_fe - fe0), 32'd1);
    check("abort_mv_count", 32'(n_mv - mv0), 32'd0);
    check("abort_mode_kept", 32'(mode_out), 32'(m_mode));
    conv_end(10);
    run_frame(v2, $urandom, 12, "abort_new");

    // Sixteen edges: only twelve shift, extra edges land in IDLE
    v = DATA_W'($urandom);
    load_sample(v);
    conv_start();
    conv_end(8);
    run_frame(v, $urandom, 16, "over16");

    // Reset mid-frame with convst held high across release
    v = DATA_W'($urandom);
    load_sample(v);
    conv_start();
    conv_end(8);
    run_frame(v, $urandom, 7, "rst_pre");
    fe0 = n_fe;
    fd0 = n_fd;
    @(negedge clk);
    convst = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("midframe_reset_outs", outs_vec(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_mode = '0;
    repeat (20) @(posedge clk);
    #1 check("held_convst_outs", outs_vec(), 32'd0);
    check("held_convst_no_fe", 32'(n_fe - fe0), 32'd0);
    check("held_convst_no_fd", 32'(n_fd - fd0), 32'd0);
    @(negedge clk);
    convst = 1'b0;
    repeat (6) @(negedge clk);
    v = DATA_W'($urandom);
    load_sample(v);
    conv_start();
    conv_end(6);
    run_frame(v, $urandom, 12, "rst_post");

    // Long convst with sck activity during busy
    v = DATA_W'($urandom);
    load_sample(v);
    conv_start();
    for (int i = 0; i < 3; i++) begin
      sck_edge(1'b1, so, fd);
      check($sformatf("busy_sck_sdo%0d", i), 32'(so), 32'd0);
      check($sformatf("busy_sck_busy%0d", i), 32'(busy), 32'd1);
    end
    conv_end(100);
    run_frame(v, $urandom, 12, "long_conv");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
